// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle; master is the pipeline side, slave is ex_stage.
interface ex_stage_if;
  logic [31:0] id_ex_pc_plus_4;
  logic [31:0] id_ex_busA;
  logic [31:0] id_ex_busB;
  logic [31:0] id_ex_imm32;
  logic [4:0]  id_ex_shamt;
  logic [3:0]  id_ex_aluop;
  logic        id_ex_alusrc;
  logic [2:0]  id_ex_muldiv_op;
  logic        id_ex_memwr;
  logic        id_ex_memread;
  logic        id_ex_regwrite;
  logic [1:0]  id_ex_memtoreg;
  logic [4:0]  id_ex_regwraddress;
  logic [1:0]  fwdA_sel;
  logic [1:0]  fwdB_sel;
  logic [31:0] wb_fwd_data;
  logic        muldiv_stall;
  logic        ex_mem_memwr;
  logic        ex_mem_memread;
  logic        ex_mem_regwrite;
  logic [1:0]  ex_mem_memtoreg;
  logic [31:0] ex_mem_pc_plus_4;
  logic [31:0] ex_mem_aluout;
  logic [31:0] ex_mem_busB;
  logic [4:0]  ex_mem_regwraddress;

  modport master (
    output id_ex_pc_plus_4, id_ex_busA, id_ex_busB, id_ex_imm32, id_ex_shamt,
           id_ex_aluop, id_ex_alusrc, id_ex_muldiv_op, id_ex_memwr, id_ex_memread,
           id_ex_regwrite, id_ex_memtoreg, id_ex_regwraddress, fwdA_sel, fwdB_sel,
           wb_fwd_data,
    input  muldiv_stall, ex_mem_memwr, ex_mem_memread, ex_mem_regwrite, ex_mem_memtoreg,
           ex_mem_pc_plus_4, ex_mem_aluout, ex_mem_busB, ex_mem_regwraddress
  );

  modport slave (
    input  id_ex_pc_plus_4, id_ex_busA, id_ex_busB, id_ex_imm32, id_ex_shamt,
           id_ex_aluop, id_ex_alusrc, id_ex_muldiv_op, id_ex_memwr, id_ex_memread,
           id_ex_regwrite, id_ex_memtoreg, id_ex_regwraddress, fwdA_sel, fwdB_sel,
           wb_fwd_data,
    output muldiv_stall, ex_mem_memwr, ex_mem_memread, ex_mem_regwrite, ex_mem_memtoreg,
           ex_mem_pc_plus_4, ex_mem_aluout, ex_mem_busB, ex_mem_regwraddress
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS EX stage: forwarding + ALU, 1 cycle into EX/MEM; iterative mul/div with HI/LO when MULDIV_EN is defined.
// Backpressure: muldiv_stall (combinational) holds ID/EX and PC while busy; EX/MEM loads a bubble meanwhile.
module ex_stage (
  input  logic      clk,
  input  logic      reset,
  ex_stage_if.slave ex
);
  logic [31:0] fwd_a, fwd_b, op_b, alu_res, aluout_d;

  always_comb begin
    case (ex.fwdA_sel)
      2'd0:    fwd_a = ex.id_ex_busA;
      2'd1:    fwd_a = ex.ex_mem_aluout;
      2'd2:    fwd_a = ex.wb_fwd_data;
      default: fwd_a = '0;
    endcase
    case (ex.fwdB_sel)
      2'd0:    fwd_b = ex.id_ex_busB;
      2'd1:    fwd_b = ex.ex_mem_aluout;
      2'd2:    fwd_b = ex.wb_fwd_data;
      default: fwd_b = '0;
    endcase
  end

  assign op_b = ex.id_ex_alusrc ? ex.id_ex_imm32 : fwd_b;

  always_comb begin
    case (ex.id_ex_aluop)
      4'd0:    alu_res = fwd_a + op_b;
      4'd1:    alu_res = fwd_a - op_b;
      4'd2:    alu_res = fwd_a & op_b;
      4'd3:    alu_res = fwd_a | op_b;
      4'd4:    alu_res = fwd_a ^ op_b;
      4'd5:    alu_res = ~(fwd_a | op_b);
      4'd6:    alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
      4'd7:    alu_res = {31'd0, fwd_a < op_b};
      // Shifts take the forwarded register value, never the immediate.
      4'd8:    alu_res = fwd_b << ex.id_ex_shamt;
      4'd9:    alu_res = fwd_b >> ex.id_ex_shamt;
      4'd10:   alu_res = $signed(fwd_b) >>> ex.id_ex_shamt;
      4'd11:   alu_res = {ex.id_ex_imm32[15:0], 16'h0000};
      default: alu_res = '0;
    endcase
  end

`ifdef MULDIV_EN
  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_FIX} md_state_t;

  md_state_t   md_state;
  logic [4:0]  md_count;
  logic [31:0] hi, lo, acc_hi, acc_lo, md_opnd;
  logic        md_is_div, md_neg_a, md_neg_b, md_div0;
  logic        md_issue, issue_div, sgn_op, sa, sb;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum, rem_shift, rem_diff;
  logic [63:0] prod, prod_neg;

  assign ex.muldiv_stall = (md_state != MD_IDLE) &&
                           (ex.id_ex_muldiv_op >= 3'd1) && (ex.id_ex_muldiv_op <= 3'd6);
  assign md_issue  = (md_state == MD_IDLE) &&
                     (ex.id_ex_muldiv_op >= 3'd1) && (ex.id_ex_muldiv_op <= 3'd4);
  assign issue_div = (ex.id_ex_muldiv_op == 3'd3) || (ex.id_ex_muldiv_op == 3'd4);
  assign sgn_op    = (ex.id_ex_muldiv_op == 3'd1) || (ex.id_ex_muldiv_op == 3'd3);
  assign sa        = sgn_op & fwd_a[31];
  assign sb        = sgn_op & fwd_b[31];
  assign mag_a     = sa ? -fwd_a : fwd_a;
  assign mag_b     = sb ? -fwd_b : fwd_b;

  // acc_hi/acc_lo hold partial product, or remainder/quotient when dividing.
  assign add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, md_opnd} : 33'd0);
  assign rem_shift = {acc_hi, acc_lo[31]};
  assign rem_diff  = rem_shift - {1'b0, md_opnd};
  assign prod      = {acc_hi, acc_lo};
  assign prod_neg  = -prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_state  <= MD_IDLE;
      md_count  <= '0;
      hi        <= '0;
      lo        <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      md_opnd   <= '0;
      md_is_div <= 1'b0;
      md_neg_a  <= 1'b0;
      md_neg_b  <= 1'b0;
      md_div0   <= 1'b0;
    end else begin
      case (md_state)
        MD_IDLE: if (md_issue) begin
          md_state  <= MD_RUN;
          md_count  <= '0;
          md_is_div <= issue_div;
          md_neg_a  <= sa;
          md_neg_b  <= sb;
          md_div0   <= (fwd_b == 32'd0);
          acc_hi    <= '0;
          acc_lo    <= issue_div ? mag_a : mag_b;
          md_opnd   <= issue_div ? mag_b : mag_a;
        end
        MD_RUN: begin
          if (!md_is_div) begin
            {acc_hi, acc_lo} <= {add_sum, acc_lo[31:1]};
          end else if (!rem_diff[32]) begin
            acc_hi <= rem_diff[31:0];
            acc_lo <= {acc_lo[30:0], 1'b1};
          end else begin
            acc_hi <= rem_shift[31:0];
            acc_lo <= {acc_lo[30:0], 1'b0};
          end
          md_count <= md_count + 5'd1;
          if (md_count == 5'd31) md_state <= MD_FIX;
        end
        MD_FIX: begin
          // A zero divisor leaves |dividend| in the remainder, so HI comes out as the dividend.
          if (!md_is_div) begin
            {hi, lo} <= (md_neg_a ^ md_neg_b) ? prod_neg : prod;
          end else begin
            hi <= md_neg_a ? -acc_hi : acc_hi;
            lo <= md_div0 ? 32'hFFFF_FFFF : ((md_neg_a ^ md_neg_b) ? -acc_lo : acc_lo);
          end
          md_state <= MD_IDLE;
        end
        default: md_state <= MD_IDLE;
      endcase
    end
  end

  always_comb begin
    case (ex.id_ex_muldiv_op)
      3'd5:    aluout_d = hi;
      3'd6:    aluout_d = lo;
      default: aluout_d = alu_res;
    endcase
  end
`else
  assign ex.muldiv_stall = 1'b0;

  always_comb begin
    case (ex.id_ex_muldiv_op)
      3'd5, 3'd6: aluout_d = '0;
      default:    aluout_d = alu_res;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex.ex_mem_memwr        <= 1'b0;
      ex.ex_mem_memread      <= 1'b0;
      ex.ex_mem_regwrite     <= 1'b0;
      ex.ex_mem_memtoreg     <= '0;
      ex.ex_mem_pc_plus_4    <= '0;
      ex.ex_mem_aluout       <= '0;
      ex.ex_mem_busB         <= '0;
      ex.ex_mem_regwraddress <= '0;
    end else if (ex.muldiv_stall) begin
      ex.ex_mem_memwr        <= 1'b0;
      ex.ex_mem_memread      <= 1'b0;
      ex.ex_mem_regwrite     <= 1'b0;
      ex.ex_mem_memtoreg     <= '0;
      ex.ex_mem_pc_plus_4    <= '0;
      ex.ex_mem_aluout       <= '0;
      ex.ex_mem_busB         <= '0;
      ex.ex_mem_regwraddress <= '0;
    end else begin
      ex.ex_mem_memwr        <= ex.id_ex_memwr;
      ex.ex_mem_memread      <= ex.id_ex_memread;
      ex.ex_mem_regwrite     <= ex.id_ex_regwrite;
      ex.ex_mem_memtoreg     <= ex.id_ex_memtoreg;
      ex.ex_mem_pc_plus_4    <= ex.id_ex_pc_plus_4;
      ex.ex_mem_aluout       <= aluout_d;
      ex.ex_mem_busB         <= fwd_b;
      ex.ex_mem_regwraddress <= ex.id_ex_regwraddress;
    end
  end
endmodule
